// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data
// load/store. The grant FSM moves IDLE -> GRANT -> RESP. Ties go to the side
// that was not served last. A watchdog aborts a grant that never sees ACCESS.
// All outputs decode from registered state only.
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              err,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;
    localparam logic KIND_READ  = 1'b0;
    localparam logic KIND_WRITE = 1'b1;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q;
    logic              kind_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic [WORD_W-1:0] iload_q;
    logic [WORD_W-1:0] dload_q;
    logic              err_q;

    // Arbitration and completion decode shared by the FSM and the datapath.
    logic i_req, d_req, grant_valid, grant_owner;
    logic access_hit, abort_hit;

    // Pick the requester: an uncontested side wins, a tie goes away from last_grant.
    always_comb begin
        i_req       = iREN;
        d_req       = dREN | dWEN;
        grant_valid = i_req | d_req;
        grant_owner = OWN_INST;
        if (i_req && d_req) begin
            grant_owner = (last_grant_q == OWN_DATA) ? OWN_INST : OWN_DATA;
        end else if (d_req) begin
            grant_owner = OWN_DATA;
        end
        access_hit = (state_q == S_GRANT) && (ramstate == RAM_ACCESS);
        abort_hit  = (state_q == S_GRANT) && (ramstate != RAM_ACCESS) &&
                     ((ramstate == RAM_ERROR) || (cnt_q == CNT_LAST));
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RESP always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_valid) state_d = S_GRANT;
            S_GRANT: if (access_hit || abort_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
        iwait  = 1'b1;
        dwait  = 1'b1;
        err    = 1'b0;
        case (state_q)
            S_GRANT: begin
                ramREN = (kind_q == KIND_READ);
                ramWEN = (kind_q == KIND_WRITE);
            end
            S_RESP: begin
                iwait = (owner_q != OWN_INST);
                dwait = (owner_q != OWN_DATA);
                err   = err_q;
            end
            default: ;
        endcase
    end

    // Transaction latches, watchdog counter, load capture and fairness flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            owner_q      <= OWN_INST;
            kind_q       <= KIND_READ;
            last_grant_q <= OWN_DATA;
            cnt_q        <= '0;
            addr_q       <= '0;
            store_q      <= '0;
            iload_q      <= '0;
            dload_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (state_q == S_IDLE && grant_valid) begin
                owner_q <= grant_owner;
                kind_q  <= (grant_owner == OWN_DATA && dWEN) ? KIND_WRITE : KIND_READ;
                addr_q  <= (grant_owner == OWN_DATA) ? daddr : iaddr;
                if (grant_owner == OWN_DATA) begin
                    store_q <= dstore;
                end
                cnt_q   <= '0;
            end
            if (state_q == S_GRANT && ramstate != RAM_ACCESS && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (access_hit) begin
                if (owner_q == OWN_INST) begin
                    iload_q <= ramload;
                end else if (kind_q == KIND_READ) begin
                    dload_q <= ramload;
                end
                err_q        <= 1'b0;
                last_grant_q <= owner_q;
            end else if (abort_hit) begin
                err_q        <= 1'b1;
                last_grant_q <= owner_q;
            end
        end
    end

    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, instruction read, contention,
// timeout, RAM error, request withdrawal and reset during a grant.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        err;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.WORD_W(32), .TIMEOUT(15)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .iload    (iload),
        .dwait    (dwait),
        .dload    (dload),
        .err      (err),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = 2'd1;

        // Reset held two cycles with iREN high.
        tick(); tick();
        $display("step reset");
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);

        // Instruction read, ACCESS on the 2nd GRANT cycle.
        nRST = 1'b1;
        tick();
        $display("step inst read");
        chk("ird_g1_ramREN", {31'b0, ramREN}, 32'd1);
        chk("ird_g1_ramaddr", ramaddr, 32'h40);
        chk("ird_g1_iwait", {31'b0, iwait}, 32'd1);
        tick();
        chk("ird_g2_ramREN", {31'b0, ramREN}, 32'd1);
        ramstate = 2'd2; ramload = 32'h3C010001;
        tick();
        chk("ird_resp_iwait", {31'b0, iwait}, 32'd0);
        chk("ird_resp_iload", iload, 32'h3C010001);
        chk("ird_resp_ramREN", {31'b0, ramREN}, 32'd0);
        chk("ird_resp_err", {31'b0, err}, 32'd0);
        chk("ird_resp_dwait", {31'b0, dwait}, 32'd1);
        iREN = 1'b0; ramstate = 2'd0;
        tick();
        chk("ird_idle_iwait", {31'b0, iwait}, 32'd1);
        chk("ird_idle_iload", iload, 32'h3C010001);

        // Fresh reset so last_grant is DATA, then contention.
        nRST = 1'b0;
        tick();
        nRST = 1'b1; iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1;
        daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = 2'd2; ramload = 32'h11111111;
        tick();
        $display("step contention grant 1 (inst)");
        chk("ct1_ramREN", {31'b0, ramREN}, 32'd1);
        chk("ct1_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("ct1_ramaddr", ramaddr, 32'h44);
        tick();
        chk("ct1_iwait", {31'b0, iwait}, 32'd0);
        chk("ct1_dwait", {31'b0, dwait}, 32'd1);
        chk("ct1_iload", iload, 32'h11111111);
        tick();
        chk("ct1_idle_iwait", {31'b0, iwait}, 32'd1);
        chk("ct1_idle_ramREN", {31'b0, ramREN}, 32'd0);
        tick();
        $display("step contention grant 2 (data write)");
        chk("ct2_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("ct2_ramREN", {31'b0, ramREN}, 32'd0);
        chk("ct2_ramaddr", ramaddr, 32'h80);
        chk("ct2_ramstore", ramstore, 32'hDEADBEEF);
        tick();
        chk("ct2_dwait", {31'b0, dwait}, 32'd0);
        chk("ct2_iwait", {31'b0, iwait}, 32'd1);
        chk("ct2_dload", dload, 32'h0);
        chk("ct2_err", {31'b0, err}, 32'd0);
        tick();
        ramload = 32'h22222222;
        tick();
        $display("step contention grant 3 (inst)");
        chk("ct3_ramREN", {31'b0, ramREN}, 32'd1);
        chk("ct3_ramaddr", ramaddr, 32'h44);
        tick();
        chk("ct3_iwait", {31'b0, iwait}, 32'd0);
        chk("ct3_iload", iload, 32'h22222222);
        iREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
        tick();

        // Timeout: ramstate stuck BUSY.
        dREN = 1'b1; daddr = 32'h100; ramstate = 2'd1; ramload = 32'h33333333;
        tick();
        $display("step timeout");
        chk("to_g1_ramREN", {31'b0, ramREN}, 32'd1);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_wait_dwait", {31'b0, dwait}, 32'd1);
        end
        tick();
        chk("to_resp_dwait", {31'b0, dwait}, 32'd0);
        chk("to_resp_err", {31'b0, err}, 32'd1);
        chk("to_resp_dload", dload, 32'h0);
        chk("to_resp_ramREN", {31'b0, ramREN}, 32'd0);
        dREN = 1'b0; ramstate = 2'd0;
        tick();
        chk("to_idle_err", {31'b0, err}, 32'd0);

        // RAM ERROR on the 3rd GRANT cycle.
        dREN = 1'b1; ramstate = 2'd1; ramload = 32'h55555555;
        tick(); tick(); tick();
        $display("step ram error");
        chk("er_g3_ramREN", {31'b0, ramREN}, 32'd1);
        ramstate = 2'd3;
        tick();
        chk("er_resp_dwait", {31'b0, dwait}, 32'd0);
        chk("er_resp_err", {31'b0, err}, 32'd1);
        chk("er_resp_dload", dload, 32'h0);
        dREN = 1'b0; ramstate = 2'd0;
        tick();
        chk("er_idle_dwait", {31'b0, dwait}, 32'd1);

        // Withdraw dREN mid-GRANT: the response still happens.
        dREN = 1'b1; daddr = 32'h200; ramstate = 2'd1; ramload = 32'hCAFEF00D;
        tick();
        $display("step withdraw");
        dREN = 1'b0;
        tick();
        chk("wd_g2_ramREN", {31'b0, ramREN}, 32'd1);
        chk("wd_g2_ramaddr", ramaddr, 32'h200);
        ramstate = 2'd2;
        tick();
        chk("wd_resp_dwait", {31'b0, dwait}, 32'd0);
        chk("wd_resp_dload", dload, 32'hCAFEF00D);
        ramstate = 2'd0;
        tick();

        // Reset asserted mid-GRANT: abandon with no wait-low pulse.
        iREN = 1'b1; iaddr = 32'h300; ramstate = 2'd1;
        tick();
        $display("step reset mid-grant");
        chk("rg_ramREN", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0; iREN = 1'b0;
        tick();
        chk("rg_rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rg_rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rg_rst_ramaddr", ramaddr, 32'h0);
        chk("rg_rst_iload", iload, 32'h0);
        chk("rg_rst_dload", dload, 32'h0);
        nRST = 1'b1; ramstate = 2'd2;
        tick();
        chk("rg_after1_iwait", {31'b0, iwait}, 32'd1);
        chk("rg_after1_ramREN", {31'b0, ramREN}, 32'd0);
        tick();
        chk("rg_after2_iwait", {31'b0, iwait}, 32'd1);
        chk("rg_after2_iload", iload, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for one core: it shares the RAM port between instruction fetch and data load/store requests, and returns completion and load data to each requester through per-side wait/load signals. It sits between the datapath's instruction/data request interfaces and the RAM model, and it runs a grant state machine with round-robin fairness and a timeout watchdog.

## Interface
- WORD_W, 32, width of address, store and load data words
- TIMEOUT, 15, maximum cycles a granted request waits for ramstate ACCESS before it is aborted with an error (must be ≥1)

- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request; held until iwait is sampled low
- iaddr  in  WORD_W  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request; wins over dREN if both high
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- iwait  out  1  low for exactly one cycle when the instruction transaction completes
- iload  out  WORD_W  registered instruction word, held until the next instruction completion
- dwait  out  1  low for exactly one cycle when the data transaction completes
- dload  out  WORD_W  registered load data, updated only on data reads
- err  out  1  one-cycle pulse, coincident with the wait-low cycle, on ERROR or timeout
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address (latched)
- ramstore  out  WORD_W  RAM write data (latched)
- ramload  in  WORD_W  RAM read data, valid when ramstate is ACCESS
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- States: IDLE, GRANT, RESP. Registered owner flag (INST/DATA), registered kind (READ/WRITE), last_grant flag, wait counter.
- IDLE:
  - If a data request (dREN|dWEN) is pending and no instruction request is pending, grant DATA.
  - If only iREN is pending, grant INST.
  - If both are pending, grant the side that is not last_grant. last_grant resets to DATA, so instruction wins the first tie.
  - On grant: latch address, store data and kind (a write if dWEN), set owner, clear the counter, and go to GRANT.
  - Each requester's wait stays high while it is not in RESP.
- GRANT:
  - ramREN = (kind==READ), ramWEN = (kind==WRITE). ramaddr and ramstore come from the latches.
  - Counter increments each cycle that ramstate is not ACCESS.
  - ramstate==ACCESS: capture ramload into iload (INST) or dload (DATA read), err_next=0, go to RESP.
  - ramstate==ERROR, or counter==TIMEOUT-1 without ACCESS: do not update load registers, err_next=1, go to RESP.
  - Update last_grant to owner on leaving GRANT.
- RESP:
  - Owner's wait=0 and err=err_reg. RAM enables are low.
  - Next state is IDLE, unconditionally.
- Requests withdrawn mid-GRANT do not cancel the latched transaction; RESP still occurs.
- Request inputs are ignored outside IDLE.
- Reset (nRST low at an edge), at any state:
  - State=IDLE, last_grant=DATA, counter=0.
  - iwait=1, dwait=1, err=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
  - Any in-flight transaction is abandoned with no response.

## Timing
- All RAM-side outputs and wait/err decode from registered state only. There are no combinational paths from request inputs or ramstate to outputs.
- Latency: request sampled in IDLE at edge 0 → GRANT from cycle 1 → ACCESS sampled at edge k (k≥1) → RESP in cycle k+1 (wait low) → IDLE in cycle k+2.
- Minimum is 3 cycles request-to-IDLE, with wait low in the 2nd cycle after sampling.
- A requester may drop or change its request on the edge after it sees wait low. The next grant is taken no earlier than the IDLE cycle.
- Timeout: with no ACCESS, RESP begins exactly TIMEOUT cycles after GRANT is entered.
- Counter width is clog2(TIMEOUT+1) and it saturates, never wrapping.

## Test plan
- Reset: hold nRST low 2 cycles with iREN=1 → iwait=dwait=1, ram enables 0, iload=dload=0, err=0. Release → grant INST next cycle.
- Instruction read: iREN=1, iaddr=0x40, ramstate ACCESS on 2nd GRANT cycle with ramload=0x3C010001 → iwait low for one cycle, iload=0x3C010001, ramREN high only during GRANT, ramaddr=0x40.
- Contention: iREN and dWEN held high continuously (daddr=0x80, dstore=0xDEADBEEF), RAM returns ACCESS immediately → grants alternate INST, DATA, INST. Write sees ramWEN=1, ramstore=0xDEADBEEF, dload unchanged.
- Timeout/error: dREN=1, ramstate stuck BUSY → RESP exactly 15 cycles after GRANT, dwait low with err=1, dload unchanged. Repeat with ramstate=ERROR on cycle 3 → same response.
- Withdraw and reset: drop dREN mid-GRANT → RESP still occurs. Assert nRST mid-GRANT → IDLE next cycle, enables low, no wait-low pulse.
